// File: rtl/prg_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : prg_packet_rx
// Description : Programmer-side receive framer. Hunts for the 4-byte sync
//               word in the UART byte stream, then decodes a command byte,
//               a 32-bit big-endian payload length and the payload bytes.
//               Optional build macro PKT_RX_TIMEOUT_EN adds an inter-byte
//               idle timeout that abandons a stalled packet.
// Revision    : 1.0 - initial release
// ============================================================================
module prg_packet_rx #(
  parameter logic [31:0] MAGIC          = 32'hDEADBEEF,
  parameter logic [31:0] MAX_LEN        = 32'h0001_0000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [31:0] length,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic        pkt_done,
  output logic        len_error,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_CMD  = 2'd1,
    S_LEN  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  match_q, match_d;     // sync-word bytes matched so far
  logic [1:0]  lcnt_q, lcnt_d;       // length bytes received so far
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] length_q, length_d;
  logic [31:0] rem_q, rem_d;         // payload bytes still expected
  logic [7:0]  dout_q, dout_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        data_valid_q, data_valid_d;
  logic        data_last_q, data_last_d;
  logic        pkt_done_q, pkt_done_d;
  logic        len_error_q, len_error_d;

  logic [7:0]  magic_byte;
  logic [31:0] len_next;

`ifdef PKT_RX_TIMEOUT_EN
  logic [23:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
`else
  // The idle limit has no consumer when the timeout is compiled out.
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Select the sync-word byte expected next, most significant byte first.
  always_comb begin
    magic_byte = MAGIC[31:24];
    case (match_q)
      2'd0:    magic_byte = MAGIC[31:24];
      2'd1:    magic_byte = MAGIC[23:16];
      2'd2:    magic_byte = MAGIC[15:8];
      default: magic_byte = MAGIC[7:0];
    endcase
  end

  // Next-state and pulse decode; everything advances only on an accepted byte,
  // except the idle timeout which fires while no bytes arrive.
  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    lcnt_d       = lcnt_q;
    cmd_d        = cmd_q;
    length_d     = length_q;
    rem_d        = rem_q;
    dout_d       = dout_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;
    pkt_done_d   = 1'b0;
    len_error_d  = 1'b0;
    len_next     = {length_q[23:0], rx_data};
`ifdef PKT_RX_TIMEOUT_EN
    idle_d       = idle_q;
    timeout_d    = 1'b0;
`endif

    if (rx_ready) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == magic_byte) begin
            if (match_q == 2'd3) begin
              match_d = 2'd0;
              state_d = S_CMD;
            end else begin
              match_d = match_q + 2'd1;
            end
          end else begin
            // A mismatching byte may itself start a new sync word.
            match_d = (rx_data == MAGIC[31:24]) ? 2'd1 : 2'd0;
          end
        end

        S_CMD: begin
          cmd_d   = rx_data;
          lcnt_d  = 2'd0;
          state_d = S_LEN;
        end

        S_LEN: begin
          length_d = len_next;
          lcnt_d   = lcnt_q + 2'd1;
          if (lcnt_q == 2'd3) begin
            if (len_next > MAX_LEN) begin
              len_error_d = 1'b1;
              state_d     = S_HUNT;
            end else if (len_next == 32'd0) begin
              cmd_valid_d = 1'b1;
              pkt_done_d  = 1'b1;
              state_d     = S_HUNT;
            end else begin
              cmd_valid_d = 1'b1;
              rem_d       = len_next;
              state_d     = S_DATA;
            end
          end
        end

        S_DATA: begin
          // Payload is transparent: sync-word bytes here are plain data.
          dout_d       = rx_data;
          data_valid_d = 1'b1;
          if (rem_q <= 32'd1) begin
            data_last_d = 1'b1;
            pkt_done_d  = 1'b1;
            state_d     = S_HUNT;
          end else begin
            rem_d = rem_q - 32'd1;
          end
        end

        default: state_d = S_HUNT;
      endcase
    end

`ifdef PKT_RX_TIMEOUT_EN
    if (rx_ready || (state_q == S_HUNT)) begin
      idle_d = 24'd0;
    end else if (idle_q == (TIMEOUT_CYCLES - 24'd1)) begin
      idle_d    = 24'd0;
      timeout_d = 1'b1;
      match_d   = 2'd0;
      state_d   = S_HUNT;
    end else begin
      idle_d = idle_q + 24'd1;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counters and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q      <= 2'd0;
      lcnt_q       <= 2'd0;
      cmd_q        <= 8'd0;
      length_q     <= 32'd0;
      rem_q        <= 32'd0;
      dout_q       <= 8'd0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      match_q      <= match_d;
      lcnt_q       <= lcnt_d;
      cmd_q        <= cmd_d;
      length_q     <= length_d;
      rem_q        <= rem_d;
      dout_q       <= dout_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      pkt_done_q   <= pkt_done_d;
      len_error_q  <= len_error_d;
    end
  end

`ifdef PKT_RX_TIMEOUT_EN
  // Inter-byte idle counter and its timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= 24'd0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign length     = length_q;
  assign data_out   = dout_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign pkt_done   = pkt_done_q;
  assign len_error  = len_error_q;
  assign busy       = (state_q != S_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_prg_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prg_packet_rx
// Description : Self-checking bench for prg_packet_rx. Directed byte vectors
//               with hand-computed expected outputs, plus an idle/timeout
//               sequence that depends on PKT_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prg_packet_rx;

  // Expected-flag bit positions: {timeout, busy, len_error, pkt_done,
  // data_last, data_valid, cmd_valid}.
  localparam logic [6:0] CV = 7'b000_0001;
  localparam logic [6:0] DV = 7'b000_0010;
  localparam logic [6:0] DL = 7'b000_0100;
  localparam logic [6:0] PD = 7'b000_1000;
  localparam logic [6:0] LE = 7'b001_0000;
  localparam logic [6:0] BY = 7'b010_0000;
  localparam logic [6:0] NO = 7'b000_0000;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [31:0] length;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_last;
  logic        pkt_done;
  logic        len_error;
  logic        timeout;
  logic        busy;

  prg_packet_rx #(
    .MAGIC          (32'hDEADBEEF),
    .MAX_LEN        (32'h0001_0000),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .length     (length),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_last  (data_last),
    .pkt_done   (pkt_done),
    .len_error  (len_error),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [7:0]  din;
    logic [6:0]  flags;
    logic [7:0]  dout;
    logic        chk;
    logic [7:0]  c;
    logic [31:0] l;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_fail;
  logic [7:0] pl [16];

  task automatic push(input logic rst, input logic rdy, input logic [7:0] din,
                      input logic [6:0] fl, input logic [7:0] dout,
                      input logic chk, input logic [7:0] c, input logic [31:0] l);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.din = din; v.flags = fl;
    v.dout = dout; v.chk = chk; v.c = c; v.l = l;
    tbl.push_back(v);
  endtask

  task automatic add_byte(input logic [7:0] din, input logic [6:0] fl);
    push(1'b0, 1'b1, din, fl, 8'h00, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic add_hdr(input logic [7:0] din, input logic [6:0] fl,
                         input logic [7:0] c, input logic [31:0] l);
    push(1'b0, 1'b1, din, fl, 8'h00, 1'b1, c, l);
  endtask

  task automatic add_data(input logic [7:0] din, input logic [6:0] fl);
    push(1'b0, 1'b1, din, fl, din, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic add_idle(input logic [7:0] din, input logic [6:0] fl);
    push(1'b0, 1'b0, din, fl, 8'h00, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic add_reset(input logic [7:0] din);
    push(1'b1, 1'b1, din, NO, 8'h00, 1'b1, 8'h00, 32'h0);
  endtask

  task automatic add_magic();
    add_byte(8'hDE, NO);
    add_byte(8'hAD, NO);
    add_byte(8'hBE, NO);
    add_byte(8'hEF, BY);
  endtask

  task automatic step(input logic rst, input logic rdy, input logic [7:0] din);
    reset    = rst;
    rx_ready = rdy;
    rx_data  = din;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] act;
  int         bad;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    pl = '{8'h64, 8'h65, 8'h72, 8'h67, 8'h20, 8'h77, 8'h61, 8'h73,
           8'h20, 8'h68, 8'h65, 8'h72, 8'h65, 8'h2E, 8'hDE, 8'hAD};

    // Reset state, with a stray byte that must be ignored.
    add_reset(8'h00);
    add_reset(8'hDE);

    // 16-byte packet "derg was here." + DE AD, with one idle gap mid-payload.
    add_magic();
    add_byte(8'h01, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h10, CV | BY, 8'h01, 32'h10);
    for (int i = 0; i < 15; i++) begin
      add_data(pl[i], DV | BY);
      if (i == 6) add_idle(8'hEF, BY);
    end
    add_data(pl[15], DV | DL | PD);
    add_idle(8'h00, NO);

    // Resync on the second DE, zero-length packet.
    add_byte(8'hDE, NO);
    add_magic();
    add_byte(8'h02, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h00, CV | PD, 8'h02, 32'h0);

    // Oversized length dropped, then a normal 1-byte packet.
    add_magic();
    add_byte(8'h05, BY);
    add_byte(8'h00, BY); add_byte(8'h02, BY); add_byte(8'h00, BY);
    add_byte(8'h00, LE);
    add_magic();
    add_byte(8'h07, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h01, CV | BY, 8'h07, 32'h1);
    add_data(8'hAA, DV | DL | PD);

    // Back-to-back packets of length 1 and 2.
    add_magic();
    add_byte(8'h03, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h01, CV | BY, 8'h03, 32'h1);
    add_data(8'h11, DV | DL | PD);
    add_magic();
    add_byte(8'h04, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h02, CV | BY, 8'h04, 32'h2);
    add_data(8'h22, DV | BY);
    add_data(8'h33, DV | DL | PD);

    // Reset after 5 of 16 payload bytes; the rest must be ignored.
    add_magic();
    add_byte(8'h09, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h10, CV | BY, 8'h09, 32'h10);
    for (int i = 0; i < 5; i++) add_data(8'h30 + 8'(i), DV | BY);
    add_reset(8'h35);
    for (int i = 0; i < 10; i++) add_byte(8'h36 + 8'(i), NO);
    add_magic();
    add_byte(8'h0A, BY);
    add_byte(8'h00, BY); add_byte(8'h00, BY); add_byte(8'h00, BY);
    add_hdr(8'h00, CV | PD, 8'h0A, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].din);
      act = {timeout, busy, len_error, pkt_done, data_last, data_valid, cmd_valid};
      n_chk++;
      if (act !== tbl[i].flags) begin
        n_fail++;
        $display("FAIL flags row %0d: got %b expected %b (to,busy,le,pd,dl,dv,cv)",
                 i, act, tbl[i].flags);
      end
      if (tbl[i].flags[1]) begin
        n_chk++;
        if (data_out !== tbl[i].dout) begin
          n_fail++;
          $display("FAIL data_out row %0d: got %h expected %h", i, data_out, tbl[i].dout);
        end
      end
      if (tbl[i].chk) begin
        n_chk++;
        if ((cmd !== tbl[i].c) || (length !== tbl[i].l)) begin
          n_fail++;
          $display("FAIL header row %0d: got cmd=%h len=%h expected cmd=%h len=%h",
                   i, cmd, length, tbl[i].c, tbl[i].l);
        end
      end
    end

    // Stall after the 2nd length byte.
    step(1'b0, 1'b1, 8'hDE);
    step(1'b0, 1'b1, 8'hAD);
    step(1'b0, 1'b1, 8'hBE);
    step(1'b0, 1'b1, 8'hEF);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    bad = 0;
`ifdef PKT_RX_TIMEOUT_EN
    for (int k = 1; k < 100; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if ((timeout !== 1'b0) || (busy !== 1'b1)) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_early: %0d bad idle cycles, expected 0", bad);
    end
    step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if ((timeout !== 1'b1) || (busy !== 1'b0) || (pkt_done !== 1'b0)) begin
      n_fail++;
      $display("FAIL timeout_fire: got to=%b busy=%b pd=%b expected to=1 busy=0 pd=0",
               timeout, busy, pkt_done);
    end
    step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if ((timeout !== 1'b0) || (busy !== 1'b0)) begin
      n_fail++;
      $display("FAIL timeout_single: got to=%b busy=%b expected to=0 busy=0", timeout, busy);
    end
`else
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if ((timeout !== 1'b0) || (busy !== 1'b1)) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d cycles lost busy or timed out, expected 0", bad);
    end
`endif
    // The stalled packet resumes normally once bytes arrive again.
    step(1'b0, 1'b0, 8'h00);
`ifndef PKT_RX_TIMEOUT_EN
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    n_chk++;
    if ((cmd_valid !== 1'b1) || (pkt_done !== 1'b1) || (cmd !== 8'h01) || (length !== 32'h0)) begin
      n_fail++;
      $display("FAIL stall_resume: got cv=%b pd=%b cmd=%h len=%h expected cv=1 pd=1 cmd=01 len=0",
               cmd_valid, pkt_done, cmd, length);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
